// File: rtl/zl_dvbs_pkg.sv
// -----------------------------------------------------------------------------
// zl_dvbs_pkg
// Shared definitions for the DVB-S transmit chain puncturer:
//   - code-rate selector values (ZL_RATE_1_2 .. ZL_RATE_7_8)
//   - puncturing pattern periods (1, 2, 3, 5, 7)
//   - X/Y keep masks per rate; bit p of a mask is the keep flag of phase p
//   - zl_pattern_lookup(): rate code -> {keep_x, keep_y, period}
//     (unused codes 5..7 fall back to rate 1/2)
// -----------------------------------------------------------------------------
package zl_dvbs_pkg;

  localparam int ZL_RATE_1_2 = 0;
  localparam int ZL_RATE_2_3 = 1;
  localparam int ZL_RATE_3_4 = 2;
  localparam int ZL_RATE_5_6 = 3;
  localparam int ZL_RATE_7_8 = 4;

  // Phase counter width covers the longest period (7).
  localparam int ZL_PHASE_W = 3;
  localparam int ZL_MASK_W  = 7;

  localparam logic [ZL_PHASE_W-1:0] ZL_PERIOD_1_2 = 3'd1;
  localparam logic [ZL_PHASE_W-1:0] ZL_PERIOD_2_3 = 3'd2;
  localparam logic [ZL_PHASE_W-1:0] ZL_PERIOD_3_4 = 3'd3;
  localparam logic [ZL_PHASE_W-1:0] ZL_PERIOD_5_6 = 3'd5;
  localparam logic [ZL_PHASE_W-1:0] ZL_PERIOD_7_8 = 3'd7;

  // Masks are written MSB = last phase, so the textual pattern reads reversed:
  // e.g. 3/4 X row "101" is phases {0,2} -> 7'b0000101.
  localparam logic [ZL_MASK_W-1:0] ZL_KEEP_X_1_2 = 7'b0000001;
  localparam logic [ZL_MASK_W-1:0] ZL_KEEP_Y_1_2 = 7'b0000001;
  localparam logic [ZL_MASK_W-1:0] ZL_KEEP_X_2_3 = 7'b0000001;
  localparam logic [ZL_MASK_W-1:0] ZL_KEEP_Y_2_3 = 7'b0000011;
  localparam logic [ZL_MASK_W-1:0] ZL_KEEP_X_3_4 = 7'b0000101;
  localparam logic [ZL_MASK_W-1:0] ZL_KEEP_Y_3_4 = 7'b0000011;
  localparam logic [ZL_MASK_W-1:0] ZL_KEEP_X_5_6 = 7'b0010101;
  localparam logic [ZL_MASK_W-1:0] ZL_KEEP_Y_5_6 = 7'b0001011;
  localparam logic [ZL_MASK_W-1:0] ZL_KEEP_X_7_8 = 7'b1010001;
  localparam logic [ZL_MASK_W-1:0] ZL_KEEP_Y_7_8 = 7'b0101111;

  typedef struct packed {
    logic [ZL_MASK_W-1:0]  keep_x;
    logic [ZL_MASK_W-1:0]  keep_y;
    logic [ZL_PHASE_W-1:0] period;
  } zl_pattern_t;

  function automatic zl_pattern_t zl_pattern_lookup(input int rate);
    zl_pattern_t pat;
    case (rate)
      ZL_RATE_2_3: pat = '{ZL_KEEP_X_2_3, ZL_KEEP_Y_2_3, ZL_PERIOD_2_3};
      ZL_RATE_3_4: pat = '{ZL_KEEP_X_3_4, ZL_KEEP_Y_3_4, ZL_PERIOD_3_4};
      ZL_RATE_5_6: pat = '{ZL_KEEP_X_5_6, ZL_KEEP_Y_5_6, ZL_PERIOD_5_6};
      ZL_RATE_7_8: pat = '{ZL_KEEP_X_7_8, ZL_KEEP_Y_7_8, ZL_PERIOD_7_8};
      default:     pat = '{ZL_KEEP_X_1_2, ZL_KEEP_Y_1_2, ZL_PERIOD_1_2};
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/zl_puncture_pattern.sv
// -----------------------------------------------------------------------------
// zl_puncture_pattern
// Combinational puncturing-matrix lookup.
// Ports:
//   rate       in  RATE_W      code-rate selector (5..7 behave as 1/2)
//   phase      in  ZL_PHASE_W  current pattern phase
//   keep_x     out 1           X bit survives at this phase
//   keep_y     out 1           Y bit survives at this phase
//   last_phase out 1           phase is the final one of the period
// -----------------------------------------------------------------------------
module zl_puncture_pattern
  import zl_dvbs_pkg::*;
#(
  parameter int RATE_W = 3
) (
  input  logic [RATE_W-1:0]     rate,
  input  logic [ZL_PHASE_W-1:0] phase,
  output logic                  keep_x,
  output logic                  keep_y,
  output logic                  last_phase
);

  zl_pattern_t pat;

  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    pat        = zl_pattern_lookup(int'(rate));
    keep_x     = pat.keep_x[phase];
    keep_y     = pat.keep_y[phase];
    last_phase = (phase == (pat.period - ZL_PHASE_W'(1)));
  end

endmodule

// File: rtl/zl_puncturer.sv
// -----------------------------------------------------------------------------
// zl_puncturer
// DVB-S rate-adaptive puncturer. Takes one coded (X,Y) pair per input
// transfer, deletes bits per the selected code rate and re-packs the
// surviving serial stream (X_p then Y_p) into (I,Q) pairs.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   rate_sel       code rate 0=1/2 1=2/3 2=3/4 3=5/6 4=7/8 (5..7 -> 1/2);
//                  sampled only at a pattern boundary (phase 0, hold empty)
//   data_in_i/q    X/Y bits from the convolutional encoder
//   data_in_req    input pair valid
//   data_in_ack    input accepted this cycle (combinational)
//   data_out_i/q   registered I/Q symbol bits
//   data_out_req   registered output valid
//   data_out_ack   downstream accepts the output pair
//   data_out_sync  (only with ZL_PUNCTURER_SYNC_EN) marks the pair whose I
//                  bit is the phase-0 X bit taken with the hold empty
// Build option: define ZL_PUNCTURER_SYNC_EN to add data_out_sync.
// -----------------------------------------------------------------------------
module zl_puncturer
  import zl_dvbs_pkg::*;
#(
  parameter int RATE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RATE_W-1:0] rate_sel,
  input  logic              data_in_i,
  input  logic              data_in_q,
  input  logic              data_in_req,
  output logic              data_in_ack,
  output logic              data_out_i,
  output logic              data_out_q,
  output logic              data_out_req,
  input  logic              data_out_ack
`ifdef ZL_PUNCTURER_SYNC_EN
  ,
  output logic              data_out_sync
`endif
);

  logic [RATE_W-1:0]     active_rate;
  logic [ZL_PHASE_W-1:0] phase;
  logic                  hold;
  logic                  hold_v;

  logic [RATE_W-1:0]     eff_rate;
  logic                  aligned;
  logic                  keep_x;
  logic                  keep_y;
  logic                  last_phase;
  logic                  single_bit;
  logic                  produce;
  logic                  pair_i;
  logic                  pair_q;
  logic                  hold_nxt;
  logic                  hold_v_nxt;
  logic                  in_fire;

  // At a pattern boundary the new rate applies to the very transfer that
  // loads it, so the lookup sees rate_sel directly there.
  assign aligned  = (phase == '0) && !hold_v;
  assign eff_rate = aligned ? rate_sel : active_rate;

  zl_puncture_pattern #(
    .RATE_W (RATE_W)
  ) u_pattern (
    .rate       (eff_rate),
    .phase      (phase),
    .keep_x     (keep_x),
    .keep_y     (keep_y),
    .last_phase (last_phase)
  );

  // Pairing of the kept bits with the hold bit. At most three bits are in
  // flight (hold + two kept), so at most one pair leaves and one bit stays.
  always_comb begin
    produce    = 1'b0;
    pair_i     = 1'b0;
    pair_q     = 1'b0;
    hold_nxt   = hold;
    hold_v_nxt = hold_v;
    single_bit = keep_x ? data_in_i : data_in_q;
    if (keep_x && keep_y) begin
      produce = 1'b1;
      if (hold_v) begin
        pair_i     = hold;
        pair_q     = data_in_i;
        hold_nxt   = data_in_q;
        hold_v_nxt = 1'b1;
      end else begin
        pair_i = data_in_i;
        pair_q = data_in_q;
      end
    end else if (hold_v) begin
      produce    = 1'b1;
      pair_i     = hold;
      pair_q     = single_bit;
      hold_v_nxt = 1'b0;
    end else begin
      hold_nxt   = single_bit;
      hold_v_nxt = 1'b1;
    end
  end

  // Stall only when this input would create a pair and the output register
  // is occupied and not being drained this cycle.
  assign data_in_ack = data_in_req && (!produce || !data_out_req || data_out_ack);
  assign in_fire     = data_in_req && data_in_ack;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the hold bit is reset with everything else so a partial pair is
  // discarded and no stale data can surface after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_rate   <= '0;
      phase         <= '0;
      hold          <= 1'b0;
      hold_v        <= 1'b0;
      data_out_req  <= 1'b0;
      data_out_i    <= 1'b0;
      data_out_q    <= 1'b0;
`ifdef ZL_PUNCTURER_SYNC_EN
      data_out_sync <= 1'b0;
`endif
    end else begin
      if (in_fire) begin
        phase  <= last_phase ? '0 : phase + ZL_PHASE_W'(1);
        hold   <= hold_nxt;
        hold_v <= hold_v_nxt;
        if (aligned) begin
          active_rate <= rate_sel;
        end
      end
      // A new pair takes priority over draining, giving back-to-back pairs
      // when data_out_ack is high.
      if (in_fire && produce) begin
        data_out_req  <= 1'b1;
        data_out_i    <= pair_i;
        data_out_q    <= pair_q;
`ifdef ZL_PUNCTURER_SYNC_EN
        // When aligned, phase 0 always keeps both bits and X becomes I.
        data_out_sync <= aligned;
`endif
      end else if (data_out_ack) begin
        data_out_req <= 1'b0;
      end
    end
  end

endmodule
